// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB round-robin arbiter: bus transfer codes, arbiter states
// and the master-index width helper.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Width of an index into a vector of n masters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotate-priority encoder: first set request strictly after ptr, wrapping, wins.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is used.
module ahb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    logic [IW-1:0] idx;
    logic          found;

    // Search order is ptr+1 .. ptr+N, so ptr itself is considered last.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign vld = found;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB2 round-robin bus arbiter with lock/burst holding and default-master parking.
// Latency: hgrant updates on the arbitration edge; hmaster/hmastlock follow one hready=1 edge later.
// Backpressure: hready=0 freezes all state; optional tenure limit via AHB_ARB_TENURE_LIMIT_EN.
import ahb_arb_pkg::*;

module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 16,
    localparam int IW            = idx_w(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [IW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] PARK_GNT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [IW-1:0] PARK_IDX = IW'(DEFAULT_MASTER);

    arb_state_e             state, state_nxt;
    logic [IW-1:0]          ptr, ptr_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_vld;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          win_idx;
    htrans_e                trans;
    logic                   burst;
    logic                   hold;
    logic                   force_arb;
    logic                   arb;

    assign trans = htrans_e'(htrans);
    assign burst = (trans == SEQ) || (trans == BUSY);

    ahb_rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req (hbusreq),
        .ptr (ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        grant_idx = '0;
        win_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i])
                grant_idx = IW'(i);
            if (pick_gnt[i])
                win_idx = IW'(i);
        end
    end

    // A master that just issued NONSEQ keeps the bus for that transfer;
    // a locked owner keeps it until it drops hlock outside a burst.
    assign hold = burst
               || (hbusreq[grant_idx] && (trans == NONSEQ))
               || ((state == LOCKED) && hlock[grant_idx]);

    assign arb = hready && (!hold || force_arb);

`ifdef AHB_ARB_TENURE_LIMIT_EN
    localparam int TW = $clog2(MAX_TENURE + 1);

    logic [TW-1:0] tcnt;

    // Counts completed cycles of an OWNED tenure while someone else waits.
    always_ff @(posedge hclk) begin
        if (!hresetn)
            tcnt <= '0;
        else if (grant_nxt != hgrant)
            tcnt <= '0;
        else if (hready && (state == OWNED) && |(hbusreq & ~hgrant)
                 && (tcnt != TW'(MAX_TENURE)))
            tcnt <= tcnt + 1'b1;
    end

    assign force_arb = (state == OWNED) && (tcnt == TW'(MAX_TENURE));
`else
    // No tenure counter in this build; MAX_TENURE only keeps the interface uniform.
    assign force_arb = 1'b0 && (MAX_TENURE > 0);
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = hgrant;
        ptr_nxt   = ptr;
        if (arb) begin
            if (pick_vld) begin
                grant_nxt = pick_gnt;
                ptr_nxt   = win_idx;
                state_nxt = hlock[win_idx] ? LOCKED : OWNED;
            end else begin
                grant_nxt = PARK_GNT;
                state_nxt = PARK;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state     <= PARK;
            ptr       <= PARK_IDX;
            hgrant    <= PARK_GNT;
            hmaster   <= PARK_IDX;
            hmastlock <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            hgrant <= grant_nxt;
            // Address phase passes to the granted master once the current transfer completes.
            if (hready) begin
                hmaster   <= grant_idx;
                hmastlock <= hlock[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural reference model.
module tb_ahb_bus_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;
    localparam int MAXT = 16;
    localparam int S_PARK = 0, S_OWN = 1, S_LOCK = 2;
`ifdef AHB_ARB_TENURE_LIMIT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic         hclk = 1'b0;
    logic         hresetn = 1'b0;
    logic [N-1:0] hbusreq = '0;
    logic [N-1:0] hlock = '0;
    logic [1:0]   htrans = 2'd0;
    logic         hready = 1'b1;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic         hmastlock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF),
        .MAX_TENURE     (MAXT)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index, arbiter mode, rotation pointer, address-phase owner.
    int m_owner = DEF, m_state = S_PARK, m_ptr = DEF, m_hm = DEF, m_tc = 0;
    bit m_ml = 1'b0;

    always @(posedge hclk) begin
        int  win, old_owner, old_state;
        bit  burst, held, forced;
        if (!hresetn) begin
            m_owner = DEF; m_state = S_PARK; m_ptr = DEF;
            m_hm = DEF; m_ml = 1'b0; m_tc = 0;
        end else if (hready) begin
            old_owner = m_owner;
            old_state = m_state;
            burst  = (htrans == 2'd1) || (htrans == 2'd3);
            held   = burst || (hbusreq[m_owner] && htrans == 2'd2)
                     || (m_state == S_LOCK && hlock[m_owner]);
            forced = TEN && (m_state == S_OWN) && (m_tc == MAXT);
            m_hm = m_owner;
            m_ml = hlock[m_owner];
            if (!held || forced) begin
                win = -1;
                for (int k = 1; k <= N; k++)
                    if (win < 0 && hbusreq[(m_ptr + k) % N])
                        win = (m_ptr + k) % N;
                if (win < 0) begin
                    m_owner = DEF;
                    m_state = S_PARK;
                end else begin
                    m_owner = win;
                    m_ptr   = win;
                    m_state = hlock[win] ? S_LOCK : S_OWN;
                end
            end
            if (m_owner != old_owner)
                m_tc = 0;
            else if (old_state == S_OWN && (hbusreq & ~(4'b0001 << old_owner)) != 0
                     && m_tc < MAXT)
                m_tc++;
        end
    end

    always @(negedge hclk) begin
        if (cmp_en) begin
            check("model_hgrant", int'(hgrant), 1 << m_owner);
            check("model_hmaster", int'(hmaster), m_hm);
            check("model_hmastlock", int'(hmastlock), int'(m_ml));
        end
    end

    task automatic cyc(input bit rn, input logic [N-1:0] req, input logic [N-1:0] lk,
                       input logic [1:0] tr, input bit rdy);
        hresetn = rn; hbusreq = req; hlock = lk; htrans = tr; hready = rdy;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // Reset, then idle
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
        cmp_en = 1'b1;
        check("reset_hgrant", int'(hgrant), 4'b0001);
        check("reset_hmaster", int'(hmaster), 0);
        check("reset_hmastlock", int'(hmastlock), 0);
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1);
        check("park_hgrant", int'(hgrant), 4'b0001);

        // Rotation among masters 1..3
        cyc(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1);
        check("rot1_hgrant", int'(hgrant), 4'b0010);
        check("rot1_hmaster", int'(hmaster), 0);
        cyc(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1);
        check("rot2_hgrant", int'(hgrant), 4'b0100);
        check("rot2_hmaster", int'(hmaster), 1);
        cyc(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1);
        check("rot3_hgrant", int'(hgrant), 4'b1000);
        check("rot3_hmaster", int'(hmaster), 2);
        cyc(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1);
        check("rot4_hgrant", int'(hgrant), 4'b0010);
        check("rot4_hmaster", int'(hmaster), 3);

        // Master 2 burst with wait states while master 1 requests
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b1);
        check("burst_grant2", int'(hgrant), 4'b0100);
        cyc(1'b1, 4'b0110, 4'b0000, 2'd2, 1'b1);
        check("burst_nonseq_hold", int'(hgrant), 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'b0110, 4'b0000, 2'd3, 1'b0);
            check("burst_wait_hgrant", int'(hgrant), 4'b0100);
            check("burst_wait_hmaster", int'(hmaster), 2);
        end
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 4'b0110, 4'b0000, 2'd3, 1'b1);
        check("burst_end_hgrant", int'(hgrant), 4'b0100);
        cyc(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b1);
        check("burst_handover", int'(hgrant), 4'b0010);

        // Locked sequence by master 3 while master 1 waits
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b1);
        cyc(1'b1, 4'b1010, 4'b1000, 2'd0, 1'b1);
        check("lock_grant3", int'(hgrant), 4'b1000);
        cyc(1'b1, 4'b1010, 4'b1000, 2'd2, 1'b1);
        check("lock_hmaster", int'(hmaster), 3);
        check("lock_hmastlock", int'(hmastlock), 1);
        cyc(1'b1, 4'b1010, 4'b1000, 2'd3, 1'b1);
        cyc(1'b1, 4'b0010, 4'b1000, 2'd0, 1'b1);
        check("lock_held", int'(hgrant), 4'b1000);
        cyc(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b1);
        check("lock_release_hgrant", int'(hgrant), 4'b0010);
        check("lock_release_hmastlock", int'(hmastlock), 0);

        // Reset in the middle of a locked sequence
        cyc(1'b1, 4'b1000, 4'b1000, 2'd0, 1'b1);
        cyc(1'b1, 4'b1000, 4'b1000, 2'd2, 1'b1);
        check("relock_hmastlock", int'(hmastlock), 1);
        cyc(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
        check("rst_lock_hgrant", int'(hgrant), 4'b0001);
        check("rst_lock_hmaster", int'(hmaster), 0);
        check("rst_lock_hmastlock", int'(hmastlock), 0);

        // Long SEQ burst by master 1 with master 2 waiting
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b1);
        check("tenure_grant1", int'(hgrant), 4'b0010);
        for (int i = 0; i < MAXT; i++)
            cyc(1'b1, 4'b0110, 4'b0000, 2'd3, 1'b1);
        check("tenure_before_limit", int'(hgrant), 4'b0010);
        cyc(1'b1, 4'b0110, 4'b0000, 2'd3, 1'b1);
`ifdef AHB_ARB_TENURE_LIMIT_EN
        check("tenure_forced_handover", int'(hgrant), 4'b0100);
`else
        for (int i = 0; i < 24; i++)
            cyc(1'b1, 4'b0110, 4'b0000, 2'd3, 1'b1);
        check("tenure_no_limit", int'(hgrant), 4'b0010);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) != 0,
                N'($urandom),
                N'($urandom & $urandom),
                2'($urandom_range(0, 3)),
                $urandom_range(0, 9) != 0);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Round-robin arbiter that shares one AHB bus between NUM_MASTERS requesting masters, such as agent BFMs or DMA engines, behind a shared AhbInterface.
- Produces hgrant, hmaster and hmastlock in AHB2 style.
- Honours locked transfers and keeps bursts atomic.
- Parks the bus on a default master when idle.
- Sits in the interconnect next to the address/data muxes, which use hmaster as their select.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, master granted when no requests are pending (park master)
MAX_TENURE, 16, cycles with hready=1 before forced handover (used only with the optional feature)

Ports:
hclk  input  1  bus clock
hresetn  input  1  reset, synchronous, active-low
hbusreq  input  NUM_MASTERS  per-master bus request
hlock  input  NUM_MASTERS  per-master locked-transfer request
htrans  input  2  htrans of the bus after the master mux (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hready  input  1  bus transfer-complete
hgrant  output  NUM_MASTERS  one-hot grant, registered
hmaster  output  $clog2(NUM_MASTERS)  address-phase owner, registered
hmastlock  output  1  current address phase is locked, registered

Behaviour:
- Reset (hresetn=0 at a posedge):
  - hgrant = 1<<DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0.
  - Round-robin pointer = DEFAULT_MASTER; state = PARK; tenure counter = 0.
  - Reset mid-burst or mid-lock abandons the ownership immediately.
- State machine:
  - PARK: no master has the bus; default master is granted.
  - OWNED: a requester holds the grant.
  - LOCKED: the owner holds a locked sequence.
- Arbitration point: a posedge where hready=1 and the grant is not held. The grant is held when any of these is true:
  - state = LOCKED;
  - htrans = SEQ or BUSY (burst in progress);
  - the granted master's hbusreq=1 and htrans = NONSEQ in this cycle, so a master keeps the bus for the transfer it just started.
- Decision at an arbitration point:
  - Search hbusreq starting from pointer+1, wrapping modulo NUM_MASTERS; first set bit wins.
  - If the current owner is the only requester, it keeps the grant.
  - With no requests: grant DEFAULT_MASTER, state = PARK.
  - Otherwise: state = OWNED, or LOCKED if hlock[winner]=1.
  - hgrant updates at this edge; the pointer moves to the winner.
- Ownership handover:
  - hmaster <= index of hgrant and hmastlock <= hlock[that index] on any posedge with hready=1.
  - hmaster therefore lags hgrant by one completed transfer (AHB2 address-phase handover).
- hready=0: hgrant, hmaster, hmastlock, pointer and state all hold.
- LOCKED exits when hlock[owner]=0 and htrans is not SEQ/BUSY at an hready=1 edge; the block then arbitrates normally on that edge.
- A request that deasserts before being granted is simply dropped. Simultaneous requests are resolved strictly by round-robin order.
- hgrant is always exactly one-hot, including in PARK.
- The block does not check hbusreq/hlock protocol violations. A master raising hlock without hbusreq is ignored.

Optional Feature:
AHB_ARB_TENURE_LIMIT_EN
- Defined:
  - A tenure counter increments on each hready=1 cycle while state=OWNED and another master's hbusreq=1; it clears on every grant change.
  - When it reaches MAX_TENURE, the next hready=1 edge is a forced arbitration point, even mid-burst. The owner must then rebuild its burst (AHB2 early burst termination).
  - LOCKED is never preempted.
- Undefined: no counter is built; a non-locked burst or continuous request can hold the bus indefinitely.

Decomposition:
- Package ahb_arb_pkg holds:
  - htrans_e enum (IDLE, BUSY, NONSEQ, SEQ);
  - arb_state_e (PARK, OWNED, LOCKED);
  - a function that derives the master-index width from NUM_MASTERS.
- One sub-module, ahb_rr_pick: purely combinational rotate-priority-encoder. Inputs are the request vector and pointer; outputs are a one-hot winner and a valid flag. The top level keeps all sequential state.

Test Plan:
- Reset then idle, NUM_MASTERS=4, DEFAULT_MASTER=0 -> hgrant=4'b0001, hmaster=0, hmastlock=0, state PARK.
- hbusreq=4'b1110 held, single NONSEQ transfers with hready=1 -> grants rotate 1,2,3,1; hmaster follows each grant one hready cycle later.
- Master 2 owns the bus in a 4-beat INCR burst, master 1 requests, hready=0 on beat 2 for 3 cycles -> grant stays on 2 until htrans returns to NONSEQ/IDLE, then passes to 1; nothing changes during the wait states.
- Master 3 requests with hlock=1 and master 1 also requests -> master 3 is granted, hmastlock=1 with hmaster=3. The grant is held until hlock[3] drops, then moves to master 1.
- hresetn=0 for one cycle mid-LOCKED -> next cycle hgrant=4'b0001, hmaster=0, hmastlock=0.
- With AHB_ARB_TENURE_LIMIT_EN and MAX_TENURE=16: master 1 runs a continuous SEQ burst while master 2 requests -> grant moves to 2 exactly after 16 hready=1 cycles. With the macro undefined, master 1 keeps the bus.
